// File: rtl/sync_register_dest_rx.sv
// Destination end of a toggle/pulse register-transfer handshake. The block synchronizes the
// request toggle, captures the held source word, offers it with valid/dequeue, and returns an ack toggle.
module sync_register_dest_rx #(
    parameter int                width  = 1,
    parameter logic [width-1:0]  init   = '0,
    parameter int                stages = 2,
    parameter bit                hold   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              sReqToggle,
    input  logic [width-1:0]  sData,
    output logic              dAckToggle,
    output logic [width-1:0]  dD_OUT,
    output logic              dVALID,
    input  logic              dDEQ,
    output logic              dPulse,
    output logic              dOVERRUN
);

    // Bit 0 of the encoding is the valid flag, so dVALID comes straight off a flop.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_STALL = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [stages-1:0]  r_sync;
    logic               r_req_seen;
    logic               r_ack;
    logic               r_pulse;
    logic               r_overrun;
    logic [width-1:0]   r_data;

    logic               w_evt;
    logic               w_accept;
    logic               w_overrun;

    always_comb begin
        w_evt       = r_sync[stages-1] ^ r_req_seen;
        w_accept    = w_evt && (!r_state[0] || dDEQ || !hold);
        w_overrun   = w_accept && r_state[0] && !dDEQ && !hold;
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = ST_FULL;
        end else if (r_state[0] && dDEQ) begin
            w_state_nxt = ST_EMPTY;
        end else if (r_state[0] && w_evt) begin
            w_state_nxt = ST_STALL;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_EMPTY;
            r_sync     <= '0;
            r_req_seen <= 1'b0;
            r_ack      <= 1'b0;
            r_pulse    <= 1'b0;
            r_overrun  <= 1'b0;
            r_data     <= init;
        end else begin
            r_state   <= w_state_nxt;
            r_sync    <= {r_sync[stages-2:0], sReqToggle};
            r_pulse   <= w_accept;
            r_overrun <= w_overrun;
            // sData is only looked at here; the source guarantees it is stable while evt is pending.
            if (w_accept) begin
                r_data     <= sData;
                r_ack      <= ~r_ack;
                r_req_seen <= r_sync[stages-1];
            end
        end
    end

    assign dAckToggle = r_ack;
    assign dD_OUT     = r_data;
    assign dVALID     = r_state[0];
    assign dPulse     = r_pulse;
    assign dOVERRUN   = r_overrun;

endmodule

// File: tb/tb_sync_register_dest_rx.sv
// Directed bench for sync_register_dest_rx: one back-pressure instance (A) and one overwrite instance (B),
// plus a soak in which a source model on a randomly scaled clock streams 1000 words into A.
module tb_sync_register_dest_rx;

    logic       clk;
    logic       sclk;
    logic       rst_n;
    int         shalf;

    logic       a_req, a_ack, a_valid, a_deq, a_pulse, a_ovr;
    logic [7:0] a_data, a_dout;
    logic       b_req, b_ack, b_valid, b_deq, b_pulse, b_ovr;
    logic [7:0] b_data, b_dout;

    logic       s_ack1, s_ack2;
    logic       src_timeout;
    logic [7:0] rx[$];

    int errors;
    int checks;

    sync_register_dest_rx #(.width(8), .init(8'hA5), .stages(2), .hold(1'b1)) u_a (
        .CLK(clk), .RST(rst_n), .sReqToggle(a_req), .sData(a_data), .dAckToggle(a_ack),
        .dD_OUT(a_dout), .dVALID(a_valid), .dDEQ(a_deq), .dPulse(a_pulse), .dOVERRUN(a_ovr)
    );

    sync_register_dest_rx #(.width(8), .init(8'hA5), .stages(2), .hold(1'b0)) u_b (
        .CLK(clk), .RST(rst_n), .sReqToggle(b_req), .sData(b_data), .dAckToggle(b_ack),
        .dD_OUT(b_dout), .dVALID(b_valid), .dDEQ(b_deq), .dPulse(b_pulse), .dOVERRUN(b_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        sclk  = 1'b0;
        shalf = 7;
    end
    always begin
        #(shalf);
        sclk = ~sclk;
    end

    // Source-side ack synchronizer of the soak source model.
    always @(posedge sclk) begin
        s_ack1 <= a_ack;
        s_ack2 <= s_ack1;
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        a_req  = 1'b0; a_data = 8'h00; a_deq = 1'b0;
        b_req  = 1'b0; b_data = 8'h00; b_deq = 1'b0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (a_dout !== 8'hA5) begin errors = errors + 1; $display("FAIL reset_dout: got %h expected a5", a_dout); end
        checks = checks + 1;
        if (a_valid !== 1'b0) begin errors = errors + 1; $display("FAIL reset_valid: got %b expected 0", a_valid); end
        checks = checks + 1;
        if (a_ack !== 1'b0) begin errors = errors + 1; $display("FAIL reset_ack: got %b expected 0", a_ack); end
        checks = checks + 1;
        if (a_pulse !== 1'b0 || a_ovr !== 1'b0) begin
            errors = errors + 1; $display("FAIL reset_strobes: got pulse=%b ovr=%b expected 0 0", a_pulse, a_ovr);
        end
        checks = checks + 1;
        if (b_dout !== 8'hA5 || b_valid !== 1'b0) begin
            errors = errors + 1; $display("FAIL reset_b: got dout=%h valid=%b expected a5 0", b_dout, b_valid);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        a_data = 8'h3C;
        a_req  = ~a_req;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (a_pulse !== 1'b0 || a_valid !== 1'b0) begin
            errors = errors + 1; $display("FAIL single_early: got pulse=%b valid=%b after 2 edges expected 0 0", a_pulse, a_valid);
        end
        @(negedge clk);
        checks = checks + 1;
        if (a_pulse !== 1'b1) begin errors = errors + 1; $display("FAIL single_pulse: got %b expected 1 at edge 3", a_pulse); end
        checks = checks + 1;
        if (a_dout !== 8'h3C || a_valid !== 1'b1 || a_ack !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL single_capture: got dout=%h valid=%b ack=%b expected 3c 1 1", a_dout, a_valid, a_ack);
        end
        @(negedge clk);
        checks = checks + 1;
        if (a_pulse !== 1'b0 || a_valid !== 1'b1) begin
            errors = errors + 1; $display("FAIL single_pulse_width: got pulse=%b valid=%b expected 0 1", a_pulse, a_valid);
        end
        a_deq = 1'b1;
        @(negedge clk);
        a_deq = 1'b0;
        checks = checks + 1;
        if (a_valid !== 1'b0) begin errors = errors + 1; $display("FAIL single_deq: got valid=%b expected 0", a_valid); end
    endtask

    task automatic test_backpressure();
        int bad;
        a_data = 8'h11;
        a_req  = ~a_req;
        repeat (4) @(negedge clk);
        checks = checks + 1;
        if (a_dout !== 8'h11 || a_valid !== 1'b1 || a_ack !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL bp_first: got dout=%h valid=%b ack=%b expected 11 1 0", a_dout, a_valid, a_ack);
        end
        a_data = 8'h22;
        a_req  = ~a_req;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_dout !== 8'h11 || a_ack !== 1'b0 || a_pulse !== 1'b0 || a_valid !== 1'b1) bad = bad + 1;
        end
        checks = checks + 1;
        if (bad !== 0) begin errors = errors + 1; $display("FAIL bp_stall: got %0d disturbed cycles expected 0", bad); end
        a_deq = 1'b1;
        @(negedge clk);
        a_deq = 1'b0;
        checks = checks + 1;
        if (a_dout !== 8'h22 || a_valid !== 1'b1 || a_ack !== 1'b1 || a_pulse !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL bp_release: got dout=%h valid=%b ack=%b pulse=%b expected 22 1 1 1", a_dout, a_valid, a_ack, a_pulse);
        end
        a_deq = 1'b1;
        @(negedge clk);
        a_deq = 1'b0;
        checks = checks + 1;
        if (a_valid !== 1'b0 || a_pulse !== 1'b0) begin
            errors = errors + 1; $display("FAIL bp_drain: got valid=%b pulse=%b expected 0 0", a_valid, a_pulse);
        end
    endtask

    task automatic test_overwrite();
        b_data = 8'h01;
        b_req  = ~b_req;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (b_dout !== 8'h01 || b_ack !== 1'b1 || b_pulse !== 1'b1 || b_ovr !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL ow_first: got dout=%h ack=%b pulse=%b ovr=%b expected 01 1 1 0", b_dout, b_ack, b_pulse, b_ovr);
        end
        b_data = 8'h02;
        b_req  = ~b_req;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (b_dout !== 8'h02 || b_ack !== 1'b0 || b_pulse !== 1'b1 || b_ovr !== 1'b1 || b_valid !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL ow_second: got dout=%h ack=%b pulse=%b ovr=%b valid=%b expected 02 0 1 1 1",
                     b_dout, b_ack, b_pulse, b_ovr, b_valid);
        end
        @(negedge clk);
        checks = checks + 1;
        if (b_ovr !== 1'b0 || b_pulse !== 1'b0) begin
            errors = errors + 1; $display("FAIL ow_strobe_width: got ovr=%b pulse=%b expected 0 0", b_ovr, b_pulse);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        a_data = 8'h55;
        a_req  = ~a_req;
        @(negedge clk);
        rst_n = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        #1;
        checks = checks + 1;
        if (a_dout !== 8'hA5 || a_valid !== 1'b0 || a_ack !== 1'b0 || a_pulse !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL midrst_async: got dout=%h valid=%b ack=%b pulse=%b expected a5 0 0 0", a_dout, a_valid, a_ack, a_pulse);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_pulse !== 1'b0 || a_valid !== 1'b0 || a_ack !== 1'b0) bad = bad + 1;
        end
        checks = checks + 1;
        if (bad !== 0) begin errors = errors + 1; $display("FAIL midrst_dropped: got %0d bad cycles expected 0", bad); end
        a_data = 8'h7E;
        a_req  = 1'b1;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (a_dout !== 8'h7E || a_valid !== 1'b1 || a_ack !== 1'b1 || a_pulse !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL midrst_after: got dout=%h valid=%b ack=%b pulse=%b expected 7e 1 1 1", a_dout, a_valid, a_ack, a_pulse);
        end
        a_deq = 1'b1;
        @(negedge clk);
        a_deq = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_soak();
        int bad;
        shalf       = $urandom_range(2, 16);
        src_timeout = 1'b0;
        rx.delete();
        repeat (4) @(posedge sclk);
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    int wcnt;
                    @(posedge sclk);
                    a_data = i[7:0];
                    a_req  = ~a_req;
                    wcnt   = 0;
                    while (s_ack2 !== a_req && wcnt < 500) begin
                        @(posedge sclk);
                        wcnt = wcnt + 1;
                    end
                    if (s_ack2 !== a_req) begin
                        src_timeout = 1'b1;
                        break;
                    end
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (rx.size() < 1000 && cyc < 60000 && !src_timeout) begin
                    @(negedge clk);
                    a_deq = ($urandom_range(0, 2) != 0);
                    if (a_deq && a_valid) rx.push_back(a_dout);
                    cyc = cyc + 1;
                end
                @(negedge clk);
                a_deq = 1'b0;
            end
        join
        checks = checks + 1;
        if (src_timeout !== 1'b0) begin errors = errors + 1; $display("FAIL soak_ack_timeout: got %b expected 0", src_timeout); end
        checks = checks + 1;
        if (rx.size() != 1000) begin errors = errors + 1; $display("FAIL soak_count: got %0d expected 1000", rx.size()); end
        bad = 0;
        for (int k = 0; k < rx.size(); k++) begin
            logic [7:0] exp_w;
            exp_w = k[7:0];
            if (rx[k] !== exp_w) bad = bad + 1;
        end
        checks = checks + 1;
        if (bad !== 0) begin errors = errors + 1; $display("FAIL soak_order: got %0d out-of-sequence words expected 0", bad); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_overwrite();
        test_reset_mid();
        test_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
